// File: rtl/alarm_tone_sequencer.sv
// alarm_tone_sequencer: drives a buzzer frequency generator with a repeating
// beep pattern (BURSTS tones separated by gaps, then a long pause) while the
// alarm is active. Supports snooze and stop.
//
// Input pulses (start/snooze/stop) are single-cycle strobes with no
// handshake; each one is sampled at the rising clk edge where it is high and
// takes effect on that same edge.
module alarm_tone_sequencer #(
  parameter int unsigned STEP_CYCLES  = 10_000_000,
  parameter int unsigned TONE_DIV_HI  = 50_000,
  parameter int unsigned TONE_DIV_LO  = 62_500,
  parameter int unsigned ON_STEPS     = 3,
  parameter int unsigned OFF_STEPS    = 2,
  parameter int unsigned BURSTS       = 4,
  parameter int unsigned PAUSE_STEPS  = 10,
  parameter int unsigned SNOOZE_STEPS = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        snooze,
  input  logic        stop,
  output logic [31:0] divider,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  state_o
);

  // Widest step count of any state sizes the shared step counter.
  localparam int unsigned MAX_A     = (ON_STEPS > OFF_STEPS) ? ON_STEPS : OFF_STEPS;
  localparam int unsigned MAX_B     = (PAUSE_STEPS > SNOOZE_STEPS) ? PAUSE_STEPS : SNOOZE_STEPS;
  localparam int unsigned MAX_STEPS = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW = (MAX_STEPS > 1)   ? $clog2(MAX_STEPS)   : 1;
  localparam int BW = (BURSTS > 1)      ? $clog2(BURSTS)      : 1;

  // A zero divider would stall the generator, so it is clamped to 1.
  localparam logic [31:0] DIV_HI = (TONE_DIV_HI == 0) ? 32'd1 : 32'(TONE_DIV_HI);
  localparam logic [31:0] DIV_LO = (TONE_DIV_LO == 0) ? 32'd1 : 32'(TONE_DIV_LO);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TONE   = 3'd1,
    ST_GAP    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_SNOOZE = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cyc_cnt;
  logic [SW-1:0]   step_cnt;
  logic [BW-1:0]   burst;
  logic [SW-1:0]   last_step;
  logic            step_pulse;
  logic            state_end;

  assign state_o = state;

  // Step pulse and the final step index of the current state.
  always_comb begin
    step_pulse = (cyc_cnt == CW'(STEP_CYCLES - 1));
    last_step  = '0;
    case (state)
      ST_TONE:   last_step = SW'(ON_STEPS - 1);
      ST_GAP:    last_step = SW'(OFF_STEPS - 1);
      ST_PAUSE:  last_step = SW'(PAUSE_STEPS - 1);
      ST_SNOOZE: last_step = SW'(SNOOZE_STEPS - 1);
      default:   last_step = '0;
    endcase
    state_end = step_pulse && (step_cnt == last_step);
  end

  // Sequencer FSM: stop beats snooze beats timed transitions; every state
  // entry clears both counters so each state lasts exactly N steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      divider  <= DIV_HI;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      cyc_cnt  <= '0;
      step_cnt <= '0;
      burst    <= '0;
    end else if (state != ST_IDLE && stop) begin
      state    <= ST_IDLE;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      cyc_cnt  <= '0;
      step_cnt <= '0;
      burst    <= '0;
    end else if (state != ST_IDLE && snooze) begin
      state    <= ST_SNOOZE;
      tone_en  <= 1'b0;
      busy     <= 1'b1;
      cyc_cnt  <= '0;
      step_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        state    <= ST_TONE;
        divider  <= DIV_HI;
        tone_en  <= 1'b1;
        busy     <= 1'b1;
        cyc_cnt  <= '0;
        step_cnt <= '0;
        burst    <= '0;
      end
    end else if (state_end) begin
      cyc_cnt  <= '0;
      step_cnt <= '0;
      case (state)
        ST_TONE: begin
          tone_en <= 1'b0;
          state   <= (burst == BW'(BURSTS - 1)) ? ST_PAUSE : ST_GAP;
        end
        ST_GAP: begin
          // Next burst index is burst+1: even exactly when burst is odd.
          state   <= ST_TONE;
          tone_en <= 1'b1;
          burst   <= burst + 1'b1;
          divider <= burst[0] ? DIV_HI : DIV_LO;
        end
        default: begin
          state   <= ST_TONE;
          tone_en <= 1'b1;
          burst   <= '0;
          divider <= DIV_HI;
        end
      endcase
    end else if (step_pulse) begin
      cyc_cnt  <= '0;
      step_cnt <= step_cnt + 1'b1;
    end else begin
      cyc_cnt  <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// tb_alarm_tone_sequencer: expected per-edge output words are queued from the
// timing rules of the beep pattern; each clock edge pops one and compares.
module tb_alarm_tone_sequencer;

  localparam int W = 37;  // {state, busy, tone_en, divider}

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        snooze;
  logic        stop;
  logic [31:0] divider;
  logic        tone_en;
  logic        busy;
  logic [2:0]  state_o;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_tests;
  int           n_fail;

  localparam logic [2:0] S_IDLE = 3'd0, S_TONE = 3'd1, S_GAP = 3'd2,
                         S_PAUSE = 3'd3, S_SNOOZE = 3'd4;

  alarm_tone_sequencer #(
    .STEP_CYCLES (4),
    .TONE_DIV_HI (10),
    .TONE_DIV_LO (20),
    .ON_STEPS    (3),
    .OFF_STEPS   (2),
    .BURSTS      (2),
    .PAUSE_STEPS (5),
    .SNOOZE_STEPS(6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .snooze (snooze),
    .stop   (stop),
    .divider(divider),
    .tone_en(tone_en),
    .busy   (busy),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d busy=%0b tone=%0b div=%0d, required st=%0d busy=%0b tone=%0b div=%0d",
               tag, got[36:34], got[33], got[32], got[31:0],
               exp[36:34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Queue n identical expected output words, one per clock edge.
  task automatic seg(input string tag, input logic [2:0] st, input logic tone,
                     input logic [31:0] div, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({st, (st != S_IDLE), tone, div});
      tag_q.push_back(tag);
    end
  endtask

  // Advance n edges; pulses set before the call apply to the first edge only.
  task automatic run(input int n);
    logic [W-1:0] e;
    string        t;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start  = 1'b0;
      snooze = 1'b0;
      stop   = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {state_o, busy, tone_en, divider}, e);
      end
    end
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    snooze  = 1'b0;
    stop    = 1'b0;

    // reset state
    seg("reset", S_IDLE, 1'b0, 32'd10, 3);
    run(3);
    rst_n = 1'b1;
    n = $urandom_range(1, 5);
    seg("idle", S_IDLE, 1'b0, 32'd10, n);
    run(n);

    // two full groups then the start of a third
    seg("g1_tone0", S_TONE,  1'b1, 32'd10, 12);
    seg("g1_gap",   S_GAP,   1'b0, 32'd10, 8);
    seg("g1_tone1", S_TONE,  1'b1, 32'd20, 12);
    seg("g1_pause", S_PAUSE, 1'b0, 32'd20, 20);
    seg("g2_tone0", S_TONE,  1'b1, 32'd10, 12);
    seg("g2_gap",   S_GAP,   1'b0, 32'd10, 8);
    seg("g2_tone1", S_TONE,  1'b1, 32'd20, 12);
    seg("g2_pause", S_PAUSE, 1'b0, 32'd20, 20);
    seg("g3_tone0", S_TONE,  1'b1, 32'd10, 5);
    start = 1'b1;
    run(109);

    // snooze mid-tone
    seg("snooze",      S_SNOOZE, 1'b0, 32'd10, 24);
    seg("post_snooze", S_TONE,   1'b1, 32'd10, 12);
    seg("post_sn_gap", S_GAP,    1'b0, 32'd10, 3);
    snooze = 1'b1;
    run(39);

    // stop and snooze together in GAP: stop wins
    seg("stop_gap", S_IDLE, 1'b0, 32'd10, 4);
    stop   = 1'b1;
    snooze = 1'b1;
    run(4);
    seg("idle_snooze", S_IDLE, 1'b0, 32'd10, 4);
    snooze = 1'b1;
    run(4);
    seg("idle_stop", S_IDLE, 1'b0, 32'd10, 2);
    stop = 1'b1;
    run(2);

    // start while busy mid-pause is ignored
    seg("r_tone0", S_TONE,  1'b1, 32'd10, 12);
    seg("r_gap",   S_GAP,   1'b0, 32'd10, 8);
    seg("r_tone1", S_TONE,  1'b1, 32'd20, 12);
    seg("r_pause", S_PAUSE, 1'b0, 32'd20, 7);
    start = 1'b1;
    run(39);
    seg("pause_start", S_PAUSE, 1'b0, 32'd20, 13);
    seg("r2_tone0",    S_TONE,  1'b1, 32'd10, 6);
    start = 1'b1;
    run(19);

    // reset mid-tone (odd burst, divider 20)
    seg("r2_tone0b", S_TONE, 1'b1, 32'd10, 6);
    seg("r2_gap",    S_GAP,  1'b0, 32'd10, 8);
    seg("r2_tone1",  S_TONE, 1'b1, 32'd20, 5);
    run(19);
    rst_n = 1'b0;
    seg("mid_reset", S_IDLE, 1'b0, 32'd10, 1);
    run(1);
    rst_n = 1'b1;
    seg("post_reset", S_IDLE, 1'b0, 32'd10, 2);
    run(2);

    // counters cleared: fresh start has full-length tone and gap
    seg("c_tone0", S_TONE, 1'b1, 32'd10, 12);
    seg("c_gap",   S_GAP,  1'b0, 32'd10, 8);
    seg("c_tone1", S_TONE, 1'b1, 32'd20, 3);
    start = 1'b1;
    run(23);

    check_eq("sb_drained", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
